// File: rtl/uart_rx_oversample.sv
// Purpose : oversampling 8N1 UART receiver (DATA_BITS configurable) with 3-sample mid-bit majority vote.
// Latency : o_rx_valid rises (16*DATA_BITS+26)*CLKS_PER_TICK clk after start-bit detection (+2..3 clk sync).
// Backpr. : byte held on o_rx_data/o_rx_valid until i_rx_ready; a byte completing while one is pending is dropped (o_overrun).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   i_rx_data    asynchronous serial line, idle high
//   o_rx_data    received byte, stable while o_rx_valid=1
//   o_rx_valid   byte available, held until accepted
//   i_rx_ready   host accept; transfer on any edge with o_rx_valid & i_rx_ready
//   o_frame_err  1-cycle pulse: stop bit voted 0, byte discarded
//   o_overrun    1-cycle pulse: new byte dropped because previous one was not accepted
module uart_rx_oversample #(
    parameter int CLKS_PER_TICK = 27,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx_data,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    // Three sample points centred on mid-bit, and the last sample slot of a bit.
    localparam logic [SW-1:0] SAMP_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t state, state_nxt;

    // Synchroniser plus one extra flop for falling-edge detection.
    logic rx_meta;
    logic rx_s;
    logic rx_d;

    logic [TW-1:0]        tick_cnt, tick_cnt_nxt;
    logic [SW-1:0]        samp_cnt, samp_cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [2:0]           samples, samples_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;
    logic                 ovr_nxt;

    logic tick;
    logic sample_pt;
    logic vote_full;
    logic vote_stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // The timebase only runs inside a frame so the first tick after
    // detection lands exactly CLKS_PER_TICK cycles later.
    assign tick      = (state != ST_IDLE) && (tick_cnt == TICK_LAST);
    assign sample_pt = (samp_cnt == SAMP_LO) || (samp_cnt == SAMP_MID) || (samp_cnt == SAMP_HI);

    // samples holds {s7, s8, s9} once the bit's last sample is in.
    assign vote_full = (samples[2] & samples[1]) | (samples[2] & samples[0]) | (samples[1] & samples[0]);
    // The stop bit commits on the third sample itself, so the live line
    // value stands in for the not-yet-registered s9 sample.
    assign vote_stop = (samples[1] & samples[0]) | (samples[1] & rx_s) | (samples[0] & rx_s);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            samples     <= '0;
            shift_reg   <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_cnt_nxt;
            samp_cnt    <= samp_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            samples     <= samples_nxt;
            shift_reg   <= shift_nxt;
            o_rx_data   <= data_nxt;
            o_rx_valid  <= valid_nxt;
            o_frame_err <= ferr_nxt;
            o_overrun   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        samp_cnt_nxt = samp_cnt;
        bit_cnt_nxt  = bit_cnt;
        samples_nxt  = samples;
        shift_nxt    = shift_reg;
        data_nxt     = o_rx_data;
        valid_nxt    = o_rx_valid;
        ferr_nxt     = 1'b0;
        ovr_nxt      = 1'b0;

        // Host handshake; a commit below may re-assert valid on the same edge.
        if (o_rx_valid && i_rx_ready) begin
            valid_nxt = 1'b0;
        end

        if (state != ST_IDLE) begin
            tick_cnt_nxt = tick ? '0 : tick_cnt + TW'(1);
        end

        if (tick) begin
            samp_cnt_nxt = samp_cnt + SW'(1);
            if (sample_pt) begin
                samples_nxt = {samples[1:0], rx_s};
            end
        end

        case (state)
            ST_IDLE: begin
                // Only a high-to-low transition starts a frame, so a line
                // held low (break) cannot re-trigger.
                if (rx_d && !rx_s) begin
                    state_nxt    = ST_START;
                    tick_cnt_nxt = '0;
                    samp_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                end
            end
            ST_START: begin
                if (tick && samp_cnt == SAMP_LAST) begin
                    if (!vote_full) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick && samp_cnt == SAMP_LAST) begin
                    shift_nxt = {vote_full, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                // Commit at the third stop sample rather than the end of the
                // bit, leaving slack for a short stop bit on back-to-back frames.
                if (tick && samp_cnt == SAMP_HI) begin
                    state_nxt    = ST_IDLE;
                    tick_cnt_nxt = '0;
                    samp_cnt_nxt = '0;
                    if (vote_stop) begin
                        if (!o_rx_valid || i_rx_ready) begin
                            data_nxt  = shift_reg;
                            valid_nxt = 1'b1;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

    localparam int CPT  = 4;
    localparam int BITC = 16 * CPT;
    // Line edge -> valid: 3 clk to detection, then 154 ticks.
    localparam int LAT  = 3 + 154 * CPT;

    localparam int K_BYTE = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       i_rx_data  = 1'b1;
    logic       i_rx_ready = 1'b0;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_overrun;

    always #5 clk = ~clk;

    uart_rx_oversample #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (16),
        .DATA_BITS    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_data  (i_rx_data),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .i_rx_ready (i_rx_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    int n_checks   = 0;
    int n_pass     = 0;
    int cyc        = 0;
    int last_start = 0;
    int vld_hi     = 0;

    typedef struct {
        int         kind;
        logic [7:0] dat;
        bit         lat;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int kind, input logic [7:0] dat, input bit lat);
        exp_t e;
        e.kind = kind;
        e.dat  = dat;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic expect_evt(input int kind, input logic [7:0] dat);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none", kind, dat);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == K_BYTE && e.kind == K_BYTE) check("rx_data", dat, e.dat);
            if (e.lat) check("latency", cyc - last_start, LAT);
        end
    endtask

    // Monitor: a byte is newly presented when valid is high and it was not
    // simply held over from an unaccepted previous cycle.
    logic vld_before = 1'b0;
    logic acc_edge   = 1'b0;

    always @(posedge clk) begin
        vld_before <= o_rx_valid;
        acc_edge   <= o_rx_valid & i_rx_ready;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (o_rx_valid) vld_hi++;
            if (o_frame_err) expect_evt(K_FERR, 8'h00);
            if (o_overrun) expect_evt(K_OVR, 8'h00);
            if (o_rx_valid && !(vld_before && !acc_edge)) expect_evt(K_BYTE, o_rx_data);
        end
    end

    // Drive one frame at BITC clk/bit. gbit inverts the line for one tick
    // around the s=8 sample of that frame bit; cut aborts after that many clk.
    task automatic send(input logic [7:0] d, input logic stopv, input int gbit, input int cut);
        logic [9:0] fr;
        fr = {stopv, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BITC; c++) begin
                if (cut >= 0 && (b * BITC + c) >= cut) return;
                @(negedge clk);
                if (b == 0 && c == 0) last_start = cyc;
                i_rx_data = fr[b] ^ ((b == gbit) && (c >= 34) && (c < 38));
            end
        end
    endtask

    task automatic check_zero_outputs();
        check("reset_valid", int'(o_rx_valid), 0);
        check("reset_data", int'(o_rx_data), 0);
        check("reset_frame_err", int'(o_frame_err), 0);
        check("reset_overrun", int'(o_overrun), 0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_zero_outputs();
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte, ready held high: 1-cycle valid pulse at fixed latency.
        i_rx_ready = 1'b1;
        vld_hi = 0;
        push(K_BYTE, 8'hA5, 1'b1);
        send(8'hA5, 1'b1, -1, -1);
        repeat (20) @(negedge clk);
        check("valid_pulse_width", vld_hi, 1);

        // Back-to-back with no ready: second byte dropped as overrun.
        i_rx_ready = 1'b0;
        push(K_BYTE, 8'h3C, 1'b0);
        push(K_OVR, 8'h00, 1'b0);
        send(8'h3C, 1'b1, -1, -1);
        send(8'hC3, 1'b1, -1, -1);
        repeat (20) @(negedge clk);
        i_rx_ready = 1'b1;
        @(negedge clk);
        i_rx_ready = 1'b0;
        check("valid_after_accept", int'(o_rx_valid), 0);
        check("data_after_accept", int'(o_rx_data), 'h3C);

        // Stop bit low, then break: one frame error, no spurious frame.
        push(K_FERR, 8'h00, 1'b0);
        send(8'h55, 1'b0, -1, -1);
        i_rx_data = 1'b0;
        repeat (500) @(negedge clk);
        i_rx_data = 1'b1;
        repeat (300) @(negedge clk);
        check("valid_after_break", int'(o_rx_valid), 0);

        // 20-clk glitch on idle line is rejected at the start-bit check.
        i_rx_data = 1'b0;
        repeat (20) @(negedge clk);
        i_rx_data = 1'b1;
        repeat (200) @(negedge clk);

        // One-tick glitch on the middle sample of data bit 3 is outvoted.
        push(K_BYTE, 8'hF0, 1'b0);
        send(8'hF0, 1'b1, 4, -1);
        repeat (20) @(negedge clk);

        // Reset mid data bit 4 while 0xF0 is still pending.
        send(8'h5A, 1'b1, -1, 5 * BITC + 32);
        reset = 1'b0;
        i_rx_data = 1'b1;
        #1;
        check_zero_outputs();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        i_rx_ready = 1'b1;
        push(K_BYTE, 8'h81, 1'b0);
        send(8'h81, 1'b1, -1, -1);
        repeat (20) @(negedge clk);

        // Commit on the same edge the host accepts the held byte.
        i_rx_ready = 1'b0;
        push(K_BYTE, 8'h11, 1'b0);
        send(8'h11, 1'b1, -1, -1);
        repeat (20) @(negedge clk);
        push(K_BYTE, 8'h22, 1'b0);
        fork
            send(8'h22, 1'b1, -1, -1);
            begin
                @(negedge clk);
                repeat (LAT - 1) @(negedge clk);
                i_rx_ready = 1'b1;
                @(negedge clk);
                i_rx_ready = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        i_rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        i_rx_ready = 1'b0;
        repeat (50) @(negedge clk);

        check("events_outstanding", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
